q_tile_reader: RTL and testbench
================================

Name: q_tile_reader

Overview:
- Reads projected Q tiles back out of the Q output SRAM: 128-bit words, 7-bit address, 4 words per 4x4 FP32 tile, word k holding tile bits [k*128+:128].
- Reassembles each tile into a 512-bit vector and presents it to the downstream attention-score stage over a valid/ready handshake.
- Is the read side of the memory that the Q projection engine fills.
- Owns the SRAM port (CEB/WEN, active-low) while busy.

Parameters:
- ADDR_WIDTH, 7, SRAM word address width.
- WORD_WIDTH, 128, SRAM data width (4 FP32 values).
- WORDS_PER_TILE, 4, words per tile; tile width = WORD_WIDTH*WORDS_PER_TILE.
- CNT_WIDTH, 6, width of tile count / index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a read job (ignored unless IDLE).
- abort  in  1  cancel job; highest priority after reset.
- base_addr  in  ADDR_WIDTH  word address of the first tile, sampled on accepted start.
- num_tiles  in  CNT_WIDTH  tiles to read, sampled on accepted start.
- MEM_DOUT  in  WORD_WIDTH  SRAM read data, valid one cycle after a CEB=0 read.
- MEM_CEB  out  1  SRAM chip enable, active-low.
- MEM_WEN  out  1  SRAM write enable, active-low; tied 1 (read only).
- MEM_ADDR  out  ADDR_WIDTH  SRAM address.
- tile_valid  out  1  tile_data holds a complete tile.
- tile_ready  in  1  consumer accepts the tile when tile_valid & tile_ready.
- tile_data  out  WORD_WIDTH*WORDS_PER_TILE  assembled tile.
- tile_idx  out  CNT_WIDTH  index (0-based) of the presented tile.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse after the last tile handshake.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State = IDLE.
  - MEM_CEB=1, MEM_WEN=1, MEM_ADDR=0.
  - tile_valid=0, tile_data=0, tile_idx=0, busy=0, done=0.
  - Internal counters cleared.
- State IDLE: on start, latch base_addr into cur_addr and num_tiles into tiles_left.
  - num_tiles==0: go to FINISH (no SRAM access).
  - Otherwise: go to ISSUE with word counter k=0.
- State ISSUE (WORDS_PER_TILE cycles):
  - MEM_CEB=0 and MEM_ADDR=cur_addr, both driven combinationally from state and cur_addr.
  - cur_addr increments each cycle, wrapping modulo 2^ADDR_WIDTH (127 -> 0).
  - After k=WORDS_PER_TILE-1, go to DRAIN.
- Capture: MEM_DOUT is sampled the cycle after each read into tile_data[j*128+:128], j = read order.
  - The capture of word 3 occurs in DRAIN.
  - MEM_CEB=1 in DRAIN.
- State DRAIN (1 cycle): go to PRESENT.
- State PRESENT:
  - tile_valid=1.
  - tile_data and tile_idx are held stable while tile_ready=0; the SRAM is idle.
  - On handshake: tiles_left-1 and tile_idx+1.
    - If tiles remain: go to ISSUE, and tile_valid drops the next cycle.
    - Else: go to FINISH.
- State FINISH: done=1 for exactly one cycle, then IDLE. tile_idx resets to 0 on the next accepted start.
- Latency, start accepted at cycle T0:
  - Reads at T1..T4.
  - tile_valid first high at T6.
  - Each further tile with tile_ready held 1: 6 cycles per tile (handshake cycle, 4 ISSUE, 1 DRAIN).
- Boundary conditions:
  - start while busy: ignored, no state change.
  - abort (any non-IDLE state): next cycle state=IDLE, MEM_CEB=1, tile_valid=0, no done pulse. tile_data is not cleared.
  - abort and start together in IDLE: abort wins, start ignored.
  - Reset mid-job: identical to the reset values above; any in-flight SRAM read data is discarded.
  - tile_ready asserted while tile_valid=0: no effect.
  - num_tiles=63 with base_addr near the top: addresses wrap, no error flag.
- MEM_WEN is never 0; the block never writes the SRAM.

Test Plan:
- Basic read: SRAM preloaded with words 0..3 = 128'h0..0_1..4 pattern; start base_addr=0, num_tiles=1, tile_ready=1 -> MEM_CEB low T1-T4 with MEM_ADDR 0,1,2,3; tile_valid at T6 with tile_data = {w3,w2,w1,w0}, tile_idx=0; done pulse at T7.
- Stream of 32 tiles: base_addr=0, num_tiles=32, tile_ready=1 -> 32 handshakes 6 cycles apart, tile_idx 0..31, addresses 0..127 each read once, single done pulse.
- Backpressure: num_tiles=2, tile_ready=0 for 10 cycles after first tile_valid -> tile_data/tile_idx stable, MEM_CEB=1 throughout the stall; second tile reads start the cycle after ready rises.
- Wrap and zero: base_addr=126, num_tiles=1 -> MEM_ADDR 126,127,0,1. Separately, num_tiles=0 -> no CEB activity, done one cycle after start.
- Abort/start conflicts: abort at T3 of a 4-tile job -> IDLE at T4, MEM_CEB=1, no tile_valid, no done. Start pulsed while busy -> ignored, job completes unchanged.
- Reset mid-PRESENT: rst_n low one cycle while tile_valid=1 -> all outputs at reset values next cycle; a fresh start then behaves exactly as the basic read.

Source files
------------

// File: rtl/q_tile_reader.sv
// q_tile_reader: reads 4x4 FP32 Q tiles back out of the Q output SRAM.
// Each tile is stored as WORDS_PER_TILE consecutive 128-bit words. The block
// reassembles the words into one wide vector and offers it downstream over a
// valid/ready handshake. It only ever reads the SRAM.
module q_tile_reader #(
   parameter int ADDR_WIDTH     = 7,
   parameter int WORD_WIDTH     = 128,
   parameter int WORDS_PER_TILE = 4,
   parameter int CNT_WIDTH      = 6
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic                                 abort,
   input  logic [ADDR_WIDTH-1:0]                base_addr,
   input  logic [CNT_WIDTH-1:0]                 num_tiles,
   input  logic [WORD_WIDTH-1:0]                MEM_DOUT,
   output logic                                 MEM_CEB,
   output logic                                 MEM_WEN,
   output logic [ADDR_WIDTH-1:0]                MEM_ADDR,
   output logic                                 tile_valid,
   input  logic                                 tile_ready,
   output logic [WORD_WIDTH*WORDS_PER_TILE-1:0] tile_data,
   output logic [CNT_WIDTH-1:0]                 tile_idx,
   output logic                                 busy,
   output logic                                 done
);

   localparam int KW = (WORDS_PER_TILE > 1) ? $clog2(WORDS_PER_TILE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS_PER_TILE - 1);
   localparam logic [CNT_WIDTH-1:0] ONE_TILE = CNT_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      DRAIN,
      PRESENT,
      FINISH
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [CNT_WIDTH-1:0]  tiles_left;
   logic [KW-1:0]         word_cnt;
   logic [KW-1:0]         rd_slot;
   logic                  rd_pending;

   // The SRAM port is only driven while issuing reads; the address is parked
   // at zero otherwise so the bus is quiet between tiles.
   assign MEM_CEB  = (state != ISSUE);
   assign MEM_WEN  = 1'b1;
   assign MEM_ADDR = (state == ISSUE) ? cur_addr : '0;
   assign busy     = (state != IDLE);

   // Job sequencer: issues the reads of one tile, captures the returning
   // words one cycle later, then holds the tile until the consumer takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_addr   <= '0;
         tiles_left <= '0;
         word_cnt   <= '0;
         rd_slot    <= '0;
         rd_pending <= 1'b0;
         tile_valid <= 1'b0;
         tile_data  <= '0;
         tile_idx   <= '0;
         done       <= 1'b0;
      end else if (abort && (state != IDLE)) begin
         // Any read still in flight is dropped; the last tile stays visible.
         state      <= IDLE;
         rd_pending <= 1'b0;
         tile_valid <= 1'b0;
         done       <= 1'b0;
         word_cnt   <= '0;
      end else begin
         done       <= 1'b0;
         rd_pending <= 1'b0;

         if (rd_pending) begin
            for (int j = 0; j < WORDS_PER_TILE; j++) begin
               if (rd_slot == KW'(j)) begin
                  tile_data[j*WORD_WIDTH +: WORD_WIDTH] <= MEM_DOUT;
               end
            end
         end

         case (state)
            IDLE: begin
               if (start && !abort) begin
                  cur_addr   <= base_addr;
                  tiles_left <= num_tiles;
                  tile_idx   <= '0;
                  word_cnt   <= '0;
                  if (num_tiles == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               cur_addr   <= cur_addr + ADDR_WIDTH'(1);
               rd_pending <= 1'b1;
               rd_slot    <= word_cnt;
               if (word_cnt == K_LAST) begin
                  word_cnt <= '0;
                  state    <= DRAIN;
               end else begin
                  word_cnt <= word_cnt + KW'(1);
               end
            end

            DRAIN: begin
               state      <= PRESENT;
               tile_valid <= 1'b1;
            end

            PRESENT: begin
               if (tile_ready) begin
                  tile_valid <= 1'b0;
                  tiles_left <= tiles_left - ONE_TILE;
                  tile_idx   <= tile_idx + ONE_TILE;
                  word_cnt   <= '0;
                  if (tiles_left == ONE_TILE) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end

            FINISH: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_tile_reader.sv
// tb_q_tile_reader: directed bench for q_tile_reader with a behavioural
// one-cycle-latency SRAM preloaded with a recognisable word pattern.
module tb_q_tile_reader;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         abort;
   logic [6:0]   base_addr;
   logic [5:0]   num_tiles;
   logic [127:0] mem_dout;
   logic         mem_ceb;
   logic         mem_wen;
   logic [6:0]   mem_addr;
   logic         tile_valid;
   logic         tile_ready;
   logic [511:0] tile_data;
   logic [5:0]   tile_idx;
   logic         busy;
   logic         done;

   logic [127:0] mem [128];

   int passed = 0;
   int total  = 0;
   logic wen_bad = 1'b0;

   int hs, nexp_addr, last_hs, cyc, dones;
   logic seen_bad;

   q_tile_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .base_addr  (base_addr),
      .num_tiles  (num_tiles),
      .MEM_DOUT   (mem_dout),
      .MEM_CEB    (mem_ceb),
      .MEM_WEN    (mem_wen),
      .MEM_ADDR   (mem_addr),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .tile_data  (tile_data),
      .tile_idx   (tile_idx),
      .busy       (busy),
      .done       (done)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // SRAM model: read data appears one cycle after a CEB=0 access.
   always @(posedge clk) begin
      if (!mem_ceb) mem_dout <= mem[mem_addr];
   end

   // Watch the write enable continuously; it must never go low.
   always @(negedge clk) begin
      if (mem_wen !== 1'b1) wen_bad = 1'b1;
   end

   function automatic logic [127:0] word_of(input int a);
      return {32'(a), 32'hCAFE_0000, 32'(a) + 32'h100, 32'hBEEF_0000 ^ 32'(a)};
   endfunction

   function automatic logic [511:0] tile_of(input int b);
      return {word_of((b + 3) % 128), word_of((b + 2) % 128),
              word_of((b + 1) % 128), word_of(b % 128)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [511:0] obs,
                               input logic [511:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic apply_start(input logic [6:0] b, input logic [5:0] n);
      base_addr = b;
      num_tiles = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Single tile from address 0 with the consumer always ready.
   task automatic basic_read();
      tile_ready = 1'b1;
      apply_start(7'd0, 6'd1);
      for (int t = 1; t <= 4; t++) begin
         check_output("basic_ceb", mem_ceb, 0);
         check_output("basic_addr", mem_addr, 512'(t - 1));
         tick();
      end
      check_output("basic_drain_ceb", mem_ceb, 1);
      check_output("basic_drain_valid", tile_valid, 0);
      tick();
      check_output("basic_valid", tile_valid, 1);
      check_output("basic_data", tile_data, tile_of(0));
      check_output("basic_word0", tile_data[127:0],
                   512'(128'h00000000_CAFE0000_00000100_BEEF0000));
      check_output("basic_idx", tile_idx, 0);
      tick();
      check_output("basic_done", done, 1);
      check_output("basic_valid_drop", tile_valid, 0);
      tick();
      check_output("basic_done_pulse", done, 0);
      check_output("basic_idle", busy, 0);
   endtask

   // Directed sequence covering reset, streaming, stalls, wrap and aborts.
   initial begin
      for (int a = 0; a < 128; a++) mem[a] = word_of(a);
      mem_dout   = '0;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      base_addr  = '0;
      num_tiles  = '0;
      tile_ready = 1'b0;
      tick();
      tick();
      check_output("rst_ceb", mem_ceb, 1);
      check_output("rst_addr", mem_addr, 0);
      check_output("rst_valid", tile_valid, 0);
      check_output("rst_data", tile_data, 0);
      check_output("rst_idx", tile_idx, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] basic read");
      basic_read();

      $display("[TB] stream of 32 tiles");
      tile_ready = 1'b1;
      hs = 0; nexp_addr = 0; last_hs = 0; dones = 0;
      apply_start(7'd0, 6'd32);
      cyc = 1;
      while (cyc < 400 && !(dones > 0 && !busy)) begin
         if (!mem_ceb) begin
            check_output("stream_addr", mem_addr, 512'(nexp_addr % 128));
            nexp_addr++;
         end
         if (tile_valid && tile_ready) begin
            check_output("stream_idx", tile_idx, 512'(hs));
            check_output("stream_data", tile_data, tile_of(hs * 4));
            if (hs > 0) check_output("stream_gap", 512'(cyc - last_hs), 6);
            else check_output("stream_first", 512'(cyc), 6);
            last_hs = cyc;
            hs++;
         end
         if (done) dones++;
         tick();
         cyc++;
      end
      check_output("stream_in_time", 512'(cyc < 400), 1);
      check_output("stream_handshakes", 512'(hs), 32);
      check_output("stream_reads", 512'(nexp_addr), 128);
      check_output("stream_dones", 512'(dones), 1);

      $display("[TB] backpressure");
      tile_ready = 1'b0;
      apply_start(7'd8, 6'd2);
      for (int t = 1; t < 6; t++) tick();
      check_output("bp_valid_first", tile_valid, 1);
      seen_bad = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (tile_valid !== 1'b1 || tile_idx !== 6'd0 ||
             tile_data !== tile_of(8) || mem_ceb !== 1'b1) seen_bad = 1'b1;
         tick();
      end
      check_output("bp_stall_stable", seen_bad, 0);
      tile_ready = 1'b1;
      check_output("bp_valid_hs", tile_valid, 1);
      tick();
      check_output("bp_resume_ceb", mem_ceb, 0);
      check_output("bp_resume_addr", mem_addr, 12);
      check_output("bp_valid_drop", tile_valid, 0);
      for (int t = 0; t < 5; t++) tick();
      check_output("bp_valid2", tile_valid, 1);
      check_output("bp_idx2", tile_idx, 1);
      check_output("bp_data2", tile_data, tile_of(12));
      tick();
      check_output("bp_done", done, 1);
      tick();

      $display("[TB] address wrap");
      apply_start(7'd126, 6'd1);
      check_output("wrap_a0", mem_addr, 126);
      tick();
      check_output("wrap_a1", mem_addr, 127);
      tick();
      check_output("wrap_a2", mem_addr, 0);
      tick();
      check_output("wrap_a3", mem_addr, 1);
      tick();
      tick();
      check_output("wrap_data", tile_data, tile_of(126));
      tick();
      check_output("wrap_done", done, 1);
      tick();

      $display("[TB] zero tiles");
      apply_start(7'd20, 6'd0);
      check_output("zero_done", done, 1);
      check_output("zero_ceb", mem_ceb, 1);
      tick();
      check_output("zero_done_pulse", done, 0);
      check_output("zero_idle", busy, 0);

      $display("[TB] abort mid-issue");
      apply_start(7'd0, 6'd4);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_output("abort_idle", busy, 0);
      check_output("abort_ceb", mem_ceb, 1);
      check_output("abort_valid", tile_valid, 0);
      seen_bad = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (tile_valid !== 1'b0 || done !== 1'b0 || mem_ceb !== 1'b1) seen_bad = 1'b1;
         tick();
      end
      check_output("abort_quiet", seen_bad, 0);

      $display("[TB] abort with start in idle");
      abort = 1'b1;
      apply_start(7'd0, 6'd1);
      abort = 1'b0;
      check_output("abort_start_busy", busy, 0);
      check_output("abort_start_ceb", mem_ceb, 1);

      $display("[TB] start while busy");
      apply_start(7'd4, 6'd1);
      tick();
      base_addr = 7'd40;
      num_tiles = 6'd3;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      check_output("busy_start_addr", mem_addr, 6);
      tick();
      tick();
      tick();
      check_output("busy_start_data", tile_data, tile_of(4));
      check_output("busy_start_idx", tile_idx, 0);
      tick();
      check_output("busy_start_done", done, 1);
      tick();
      check_output("busy_start_idle", busy, 0);

      $display("[TB] reset while presenting");
      tile_ready = 1'b0;
      apply_start(7'd16, 6'd1);
      for (int t = 1; t < 6; t++) tick();
      check_output("rstp_valid_before", tile_valid, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_output("rstp_valid", tile_valid, 0);
      check_output("rstp_data", tile_data, 0);
      check_output("rstp_idx", tile_idx, 0);
      check_output("rstp_busy", busy, 0);
      check_output("rstp_done", done, 0);
      check_output("rstp_ceb", mem_ceb, 1);
      check_output("rstp_addr", mem_addr, 0);
      basic_read();

      check_output("wen_never_low", wen_bad, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
